// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and address-field layout for the data cache controller
// Direct-mapped line of four 16-bit words; byte address = {tag, index, word, byte}.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, RETRY} state_t;

  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 5;
  localparam int INDEX_W    = 8;
  localparam int OFFSET_W   = 3;
  localparam int WORD_W     = 2;
  localparam int TAG_LSB    = 11;
  localparam int INDEX_LSB  = 3;

  function automatic logic [15:0] word_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index,
                                            input logic [WORD_W-1:0]  word);
    return {tag, index, word, 1'b0};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - cache-array and main-memory signal bundle seen by the controller
// master = controller side, slave = cache array plus memory.
interface dcache_if;
  import dcache_pkg::*;

  logic               c_en, c_comp, c_write, c_valid_in;
  logic [TAG_W-1:0]   c_tag;
  logic [INDEX_W-1:0] c_index;
  logic [OFFSET_W-1:0] c_offset;
  logic [15:0]        c_data_in;
  logic               c_hit, c_dirty, c_valid;
  logic [TAG_W-1:0]   c_tag_out;
  logic [15:0]        c_data_out;
  logic               m_rd, m_wr;
  logic [15:0]        m_addr, m_data_in;
  logic               m_stall;
  logic [15:0]        m_data_out;

  modport master (
    output c_en, c_comp, c_write, c_valid_in, c_tag, c_index, c_offset, c_data_in,
    input  c_hit, c_dirty, c_valid, c_tag_out, c_data_out,
    output m_rd, m_wr, m_addr, m_data_in,
    input  m_stall, m_data_out
  );

  modport slave (
    input  c_en, c_comp, c_write, c_valid_in, c_tag, c_index, c_offset, c_data_in,
    output c_hit, c_dirty, c_valid, c_tag_out, c_data_out,
    input  m_rd, m_wr, m_addr, m_data_in,
    output m_stall, m_data_out
  );
endinterface

// File: rtl/dcache_ctrl_fill_tracker.sv
// rtl/dcache_ctrl_fill_tracker.sv - tags each memory read return with its word offset
// One stage per cycle of read latency; the oldest stage lines up with mem_data_out.
module fill_tracker #(
  parameter int LAT   = 2,
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [1:0] offset_i,
  output logic       valid_o,
  output logic [1:0] offset_o,
  output logic       last_o
);
  logic [LAT-1:0] vld_q;
  logic [1:0]     off_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) off_q[i] <= '0;
    end else begin
      vld_q[0] <= push_i;
      off_q[0] <= offset_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        off_q[i] <= off_q[i-1];
      end
    end
  end

  assign valid_o  = vld_q[LAT-1];
  assign offset_o = off_q[LAT-1];
  assign last_o   = vld_q[LAT-1] && (off_q[LAT-1] == 2'(WORDS-1));
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped data cache controller: hit, write-back, fill, retry
// Core request inputs are held stable while Stall=1, so they double as the saved request.
module dcache_ctrl #(
  parameter int MEM_RD_LAT = 2,
  parameter int LINE_WORDS = dcache_pkg::LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        valid_req,
  output logic        Err,
  dcache_if.master    bus
);
  import dcache_pkg::*;

  localparam logic [2:0] WORDS_C = 3'(LINE_WORDS);
  localparam logic [2:0] LAST_C  = 3'(LINE_WORDS - 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               req, illegal;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic               fill_push, fill_vld, fill_last;
  logic [1:0]         fill_off;

  assign req       = Rd | Wr;
  assign illegal   = (Rd & Wr) | (req & Addr[0]);
  assign req_tag   = Addr[TAG_LSB +: TAG_W];
  assign req_index = Addr[INDEX_LSB +: INDEX_W];

  fill_tracker #(.LAT(MEM_RD_LAT), .WORDS(LINE_WORDS)) u_fill_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (fill_push),
    .offset_i (cnt_q[1:0]),
    .valid_o  (fill_vld),
    .offset_o (fill_off),
    .last_o   (fill_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fill_push      = 1'b0;
    DataOut        = '0;
    Done           = 1'b0;
    Stall          = 1'b0;
    CacheHit       = 1'b0;
    valid_req      = 1'b0;
    Err            = 1'b0;
    bus.c_en       = 1'b0;
    bus.c_comp     = 1'b0;
    bus.c_write    = 1'b0;
    bus.c_valid_in = 1'b0;
    bus.c_tag      = '0;
    bus.c_index    = '0;
    bus.c_offset   = '0;
    bus.c_data_in  = '0;
    bus.m_rd       = 1'b0;
    bus.m_wr       = 1'b0;
    bus.m_addr     = '0;
    bus.m_data_in  = '0;
    // Everything stays quiet while reset is held, even with a request pending.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (illegal) begin
            Err = 1'b1;
          end else if (req) begin
            valid_req     = 1'b1;
            bus.c_en      = 1'b1;
            bus.c_comp    = 1'b1;
            bus.c_write   = Wr;
            bus.c_tag     = req_tag;
            bus.c_index   = req_index;
            bus.c_offset  = Addr[OFFSET_W-1:0];
            bus.c_data_in = DataIn;
            if (bus.c_hit && bus.c_valid) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = Rd ? bus.c_data_out : '0;
            end else begin
              Stall   = 1'b1;
              cnt_d   = '0;
              state_d = (bus.c_valid && bus.c_dirty) ? WB : FILL;
            end
          end
        end
        WB: begin
          Stall         = 1'b1;
          bus.c_en      = 1'b1;
          bus.c_index   = req_index;
          bus.c_offset  = {cnt_q[1:0], 1'b0};
          bus.m_wr      = 1'b1;
          bus.m_addr    = word_addr(bus.c_tag_out, req_index, cnt_q[1:0]);
          bus.m_data_in = bus.c_data_out;
          if (!bus.m_stall) begin
            if (cnt_q == LAST_C) begin
              cnt_d   = '0;
              state_d = FILL;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        FILL: begin
          Stall = 1'b1;
          if (cnt_q < WORDS_C) begin
            bus.m_rd   = 1'b1;
            bus.m_addr = word_addr(req_tag, req_index, cnt_q[1:0]);
            if (!bus.m_stall) begin
              fill_push = 1'b1;
              cnt_d     = cnt_q + 3'd1;
            end
          end
          // Returns land on their own schedule, independent of issue stalls.
          if (fill_vld) begin
            bus.c_en       = 1'b1;
            bus.c_write    = 1'b1;
            bus.c_tag      = req_tag;
            bus.c_index    = req_index;
            bus.c_offset   = {fill_off, 1'b0};
            bus.c_data_in  = bus.m_data_out;
            bus.c_valid_in = fill_last;
            if (fill_last) state_d = RETRY;
          end
        end
        RETRY: begin
          Done          = 1'b1;
          bus.c_en      = 1'b1;
          bus.c_comp    = 1'b1;
          bus.c_write   = Wr;
          bus.c_tag     = req_tag;
          bus.c_index   = req_index;
          bus.c_offset  = Addr[OFFSET_W-1:0];
          bus.c_data_in = DataIn;
          DataOut       = Rd ? bus.c_data_out : '0;
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed bench for dcache_ctrl with cache-array and memory models
// Memory word w initially holds 0x4000+w; latency 2 cycles from accepted read.
module tb_dcache_ctrl;
  logic        clk, rst_n;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, valid_req, Err;

  dcache_if cif ();

  dcache_ctrl #(.MEM_RD_LAT(2), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .valid_req (valid_req),
    .Err       (Err),
    .bus       (cif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache array model
  logic [15:0] cdata [256][4];
  logic [4:0]  ctag  [256];
  logic        cval  [256];
  logic        cdirty[256];
  logic [15:0] mem   [32768];
  logic [15:0] mp0, mp1;
  bit          init_done;

  always_comb begin
    cif.c_tag_out  = ctag[cif.c_index];
    cif.c_valid    = cval[cif.c_index];
    cif.c_dirty    = cdirty[cif.c_index];
    cif.c_data_out = cdata[cif.c_index][cif.c_offset[2:1]];
    cif.c_hit      = cif.c_en && cif.c_comp && (ctag[cif.c_index] == cif.c_tag);
  end

  assign cif.m_data_out = mem[mp1[15:1]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        cval[i] <= 1'b0; cdirty[i] <= 1'b0; ctag[i] <= '0;
        for (int j = 0; j < 4; j++) cdata[i][j] <= '0;
      end
      for (int w = 0; w < 32768; w++) mem[w] <= 16'(32'h4000 + w);
      init_done <= 1'b1;
    end else begin
      if (cif.c_en && cif.c_write) begin
        if (cif.c_comp) begin
          if (cval[cif.c_index] && ctag[cif.c_index] == cif.c_tag) begin
            cdata[cif.c_index][cif.c_offset[2:1]] <= cif.c_data_in;
            cdirty[cif.c_index] <= 1'b1;
          end
        end else begin
          cdata[cif.c_index][cif.c_offset[2:1]] <= cif.c_data_in;
          ctag[cif.c_index]   <= cif.c_tag;
          cval[cif.c_index]   <= cif.c_valid_in;
          cdirty[cif.c_index] <= 1'b0;
        end
      end
      if (cif.m_wr && !cif.m_stall) mem[cif.m_addr[15:1]] <= cif.m_data_in;
    end
    mp0 <= cif.m_addr;
    mp1 <= mp0;
  end

  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; } ev_t;
  ev_t rd_q[$];
  ev_t wr_q[$];
  int  cw_q[$];
  int  overlap = 0;

  always @(negedge clk) begin
    if (cif.m_rd && cif.m_wr) overlap++;
    if (cif.m_rd && !cif.m_stall) rd_q.push_back('{cyc, cif.m_addr, 16'h0});
    if (cif.m_wr && !cif.m_stall) wr_q.push_back('{cyc, cif.m_addr, cif.m_data_in});
    if (cif.c_en && cif.c_write && !cif.c_comp) cw_q.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;
  int t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); cw_q.delete();
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, output int lat, output logic [15:0] dout,
                           output logic hit, output logic vr0, output logic st0);
    @(posedge clk); #1;
    Rd = rd; Wr = wr; Addr = a; DataIn = d; t0 = cyc;
    lat = -1; dout = 'x; hit = 'x; vr0 = 'x; st0 = 'x;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 0) begin vr0 = valid_req; st0 = Stall; end
      if (Done) begin lat = n; dout = DataOut; hit = CacheHit; end
      @(posedge clk); #1;
    end
    Rd = 1'b0; Wr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] dout;
    logic        hit, vr0, st0;
    logic [15:0] wb_exp [4];
    logic [15:0] b2b_addr [5];
    logic [15:0] b2b_exp [5];

    rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; cif.m_stall = 1'b0;
    repeat (2) @(posedge clk); #1;
    Rd = 1'b1; Addr = 16'h0010; #1;
    chk("reset_outs", {Done, Stall, CacheHit, valid_req, Err, cif.c_en, cif.m_rd, cif.m_wr}, 0);
    chk("reset_dataout", DataOut, 0);
    Rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Clean-miss store
    clear_logs();
    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, dout, hit, vr0, st0);
    chk("st_lat", lat, 7);
    chk("st_hit", hit, 0);
    chk("st_vreq0", vr0, 1);
    chk("st_stall0", st0, 1);
    chk("st_nrd", rd_q.size(), 4);
    chk("st_nwr", wr_q.size(), 0);
    for (int i = 0; i < 4 && i < rd_q.size() && i < cw_q.size(); i++) begin
      chk("st_rd_addr", rd_q[i].addr, 32'h0010 + 2 * i);
      chk("st_rd_cyc", rd_q[i].cyc - t0, 1 + i);
      chk("st_cw_cyc", cw_q[i] - t0, 3 + i);
    end

    // Hit load of the stored word
    clear_logs();
    do_access(1'b1, 1'b0, 16'h0010, 16'h0, lat, dout, hit, vr0, st0);
    chk("ld_hit_lat", lat, 0);
    chk("ld_hit_flag", hit, 1);
    chk("ld_hit_data", dout, 16'hBEEF);
    chk("ld_hit_nmem", rd_q.size() + wr_q.size(), 0);

    // Dirty eviction
    clear_logs();
    wb_exp[0] = 16'hBEEF; wb_exp[1] = 16'h4009; wb_exp[2] = 16'h400A; wb_exp[3] = 16'h400B;
    do_access(1'b1, 1'b0, 16'h0810, 16'h0, lat, dout, hit, vr0, st0);
    chk("dirty_lat", lat, 11);
    chk("dirty_hit", hit, 0);
    chk("dirty_data", dout, 16'h4408);
    chk("dirty_nwr", wr_q.size(), 4);
    chk("dirty_nrd", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size() && i < rd_q.size(); i++) begin
      chk("wb_addr", wr_q[i].addr, 32'h0010 + 2 * i);
      chk("wb_data", wr_q[i].data, wb_exp[i]);
      chk("wb_cyc", wr_q[i].cyc - t0, 1 + i);
      chk("dfill_addr", rd_q[i].addr, 32'h0810 + 2 * i);
      chk("dfill_cyc", rd_q[i].cyc - t0, 5 + i);
    end

    // Memory stall during fill word 1 (cycles 2..4)
    clear_logs();
    fork
      do_access(1'b1, 1'b0, 16'h1020, 16'h0, lat, dout, hit, vr0, st0);
      begin
        repeat (3) @(posedge clk); #1;
        cif.m_stall = 1'b1;
        repeat (3) @(posedge clk); #1;
        cif.m_stall = 1'b0;
      end
    join
    chk("mstall_lat", lat, 10);
    chk("mstall_data", dout, 16'h4810);
    chk("mstall_nrd", rd_q.size(), 4);
    if (rd_q.size() > 1) chk("mstall_w1_cyc", rd_q[1].cyc - t0, 5);

    // Illegal requests
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010;
    @(negedge clk);
    chk("ill_rdwr", {Err, cif.c_en, cif.m_rd, cif.m_wr, valid_req, Done}, 6'b100000);
    @(posedge clk); #1;
    Wr = 1'b0; Addr = 16'h0011;
    @(negedge clk);
    chk("ill_odd", {Err, cif.c_en, cif.m_rd, cif.m_wr, valid_req, Done}, 6'b100000);
    @(posedge clk); #1;
    Rd = 1'b0;
    do_access(1'b1, 1'b0, 16'h0810, 16'h0, lat, dout, hit, vr0, st0);
    chk("post_ill_lat", lat, 0);
    chk("post_ill_data", dout, 16'h4408);

    // Reset during fill word 2
    @(posedge clk); #1;
    Rd = 1'b1; Addr = 16'h2030;
    repeat (3) @(posedge clk); #1;
    chk("pre_rst_rd", {cif.m_rd, cif.m_addr}, {1'b1, 16'h2034});
    rst_n = 1'b0; #1;
    chk("rst_mid_outs", {Done, Stall, CacheHit, valid_req, Err, cif.c_en, cif.c_write,
                         cif.m_rd, cif.m_wr}, 0);
    chk("rst_mid_maddr", cif.m_addr, 0);
    Rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clear_logs();
    do_access(1'b1, 1'b0, 16'h2030, 16'h0, lat, dout, hit, vr0, st0);
    chk("rerun_vreq", vr0, 1);
    chk("rerun_lat", lat, 7);
    chk("rerun_hit", hit, 0);
    chk("rerun_nrd", rd_q.size(), 4);
    chk("rerun_data", dout, 16'h5018);

    // Back-to-back hits
    b2b_addr[0] = 16'h0810; b2b_addr[1] = 16'h0812; b2b_addr[2] = 16'h0814;
    b2b_addr[3] = 16'h0816; b2b_addr[4] = 16'h1020;
    b2b_exp[0]  = 16'h4408; b2b_exp[1]  = 16'h4409; b2b_exp[2]  = 16'h440A;
    b2b_exp[3]  = 16'h440B; b2b_exp[4]  = 16'h4810;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      Rd = 1'b1; Addr = b2b_addr[i];
      @(negedge clk);
      chk("b2b_flags", {valid_req, CacheHit, Done, Stall}, 4'b1110);
      chk("b2b_data", DataOut, b2b_exp[i]);
      @(posedge clk); #1;
    end
    Rd = 1'b0;

    // Store hit then read back
    do_access(1'b0, 1'b1, 16'h0812, 16'h1234, lat, dout, hit, vr0, st0);
    chk("sthit_lat", lat, 0);
    chk("sthit_flag", hit, 1);
    do_access(1'b1, 1'b0, 16'h0812, 16'h0, lat, dout, hit, vr0, st0);
    chk("sthit_readback", dout, 16'h1234);

    chk("no_rd_wr_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Controller FSM between the memory pipeline stage and the direct-mapped data cache plus four-bank main memory. It serves loads and stores from the cache on a hit. On a miss it writes back a dirty victim line, fills the line from memory, and retries the access. It drives the `valid_req` and `CacheHit` indications counted by the processor bench.

## Interface
Parameters:
- `MEM_RD_LAT`, 2: cycles from accepted memory read issue to valid `mem_data_out`.
- `LINE_WORDS`, 4: 16-bit words per line; address split tag[15:11], index[10:3], offset[2:0].

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Addr` in 16: byte address from memory stage.
- `DataIn` in 16: store data.
- `Rd`, `Wr` in 1: load / store request; held stable by the core while `Stall`=1.
- `DataOut` out 16: load data.
- `Done` out 1: access complete this cycle.
- `Stall` out 1: core must freeze.
- `CacheHit` out 1: access completed as a first-try hit.
- `valid_req` out 1: a new request is accepted this cycle.
- `Err` out 1: illegal request.
- Cache side outputs: `c_en`, `c_comp`, `c_write`, `c_valid_in` (1 each); `c_tag` 5; `c_index` 8; `c_offset` 3; `c_data_in` 16.
- Cache side inputs: `c_hit`, `c_dirty`, `c_valid` (1 each); `c_tag_out` 5; `c_data_out` 16.
- Memory side outputs: `m_rd`, `m_wr` (1 each); `m_addr` 16; `m_data_in` 16.
- Memory side inputs: `m_stall` 1; `m_data_out` 16.

## Operation
States:
- IDLE:
  - With `Rd^Wr`, drive a compare access (`c_en`=1, `c_comp`=1, `c_write`=`Wr`).
  - `valid_req`=1.
  - If `c_hit&c_valid`: `Done`=1, `CacheHit`=1, `Stall`=0, stay in IDLE.
  - Otherwise `Stall`=1, then go to WB if `c_valid&c_dirty`, else go to FILL.
- WB:
  - Read victim word k from the cache (`c_comp`=0, `c_write`=0).
  - Drive `m_wr`, `m_addr`={`c_tag_out`, index, k, 0}.
  - k advances only when `m_stall`=0.
  - After k=3 is accepted, go to FILL.
- FILL:
  - Issue `m_rd` for word j = 0..3 on the request address; j advances when `m_stall`=0.
  - Each returned word is written to the cache `MEM_RD_LAT` cycles after its issue (`c_comp`=0, `c_write`=1).
  - `c_valid_in`=1 only on the final word.
  - When the last word is written, go to RETRY.
- RETRY:
  - Compare access with the original `Rd`/`Wr`/`DataIn`.
  - `Done`=1, `CacheHit`=0, `Stall`=0, then go to IDLE.
- Illegal request: `Rd&Wr`, or `Addr[0]`=1 with a request. `Err`=1, no cache or memory activity, stay in IDLE, `Done`=0.
- `valid_req` is asserted only in IDLE when a legal request is present. It is never asserted during RETRY.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, counters=0; every output is 0 including `DataOut`. Any in-flight memory op is abandoned, and the line is left with valid=0 unless its final word had already been written.
- Hit: zero-cycle. `Done` in the request cycle. Load data is combinational from `c_data_out`.
- Clean miss, request at cycle 0, `m_stall`=0:
  - Reads issued at cycles 1–4.
  - Cache writes at cycles 1+L..4+L, where L=`MEM_RD_LAT`.
  - RETRY/`Done` at cycle 5+L, i.e. cycle 7 for L=2.
- Dirty miss: write-backs at cycles 1–4, then fill shifted by 4. `Done` at cycle 9+L.
- `m_stall`=1 freezes issue counters only. Returns already in flight still complete on schedule.
- `m_rd` and `m_wr` are never high in the same cycle.

## Structure
- Package `dcache_pkg`:
  - State enum {IDLE, WB, FILL, RETRY}.
  - `LINE_WORDS`.
  - Tag, index and offset widths and bit positions.
- Sub-module `fill_tracker`: a `MEM_RD_LAT`-deep shift register of {valid, offset}. It marks which cycle's `m_data_out` belongs to which word and flags the last word.

## Test plan
- Store to an empty cache, `Addr`=0x0010, `DataIn`=0xBEEF:
  - Clean miss: four `m_rd` at 0x0010/12/14/16.
  - `Done` at cycle 7.
  - A subsequent load of 0x0010 gives `CacheHit`=1 and `DataOut`=0xBEEF in 0 cycles.
- Dirty eviction: load 0x0810 (same index, tag 1) after the store above:
  - Four `m_wr` to 0x0010..0x0016, with 0xBEEF at 0x0010.
  - Then four reads from 0x0810.
  - `Done` at cycle 11.
- `m_stall` high for 3 cycles during FILL word 1: `Done` delayed by exactly 3 cycles; data intact.
- `Rd`=`Wr`=1, or `Addr`=0x0011: `Err`=1 in the same cycle; no `c_en`, no `m_rd`/`m_wr`, `valid_req`=0.
- `rst_n` pulsed low during FILL word 2: all outputs 0 immediately. The next request to the same address misses again, with `valid_req`=1 and a full refill.
- Back-to-back hits, 5 consecutive loads: `valid_req`, `CacheHit` and `Done` high every cycle; `Stall` never asserted.
